norm_shift_encoder: RTL and testbench



---
 rtl/norm_shift_encoder.sv | 130 +++++++++++++
 tb/tb_norm_shift_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_encoder.sv
// norm_shift_encoder
//   Sequential normalization-amount generator for the FPU add/subtract path.
//   Takes the raw significand sum (carry bit at SWR-1, hidden bit at SWR-2)
//   and produces the shift direction and magnitude that the barrel shifter
//   uses to renormalize the result. The leading-one search scans one bit
//   per cycle behind a load/valid handshake.
//
// Parameters
//   SWR  significand word width (SWR-2 < 2**EWR)
//   EWR  shift-amount field width
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   load_i            start request, sampled only while idle
//   Data_i            unnormalized significand sum, latched on accepted load
//   busy_o            high while an operation is in progress (incl. result cycle)
//   valid_o           one-cycle pulse, results valid from this cycle on
//   FSM_left_right_o  1 = left shift (normalize up), 0 = right (carry overflow)
//   Shift_Value_o     shift magnitude
//   zero_flag_o       latched sum was all zeros
module norm_shift_encoder #(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Data_i,
    output logic           busy_o,
    output logic           valid_o,
    output logic           FSM_left_right_o,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           zero_flag_o
);

    localparam int PW = $clog2(SWR);
    localparam logic [PW-1:0]  PTR_START = PW'(SWR - 2);
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
    localparam logic [EWR-1:0] CNT_ONE   = EWR'(1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t         state, state_nxt;
    logic [SWR-1:0] data_reg, data_nxt;
    logic [PW-1:0]  ptr, ptr_nxt;
    logic [EWR-1:0] cnt, cnt_nxt;
    logic           lr_nxt;
    logic [EWR-1:0] shift_nxt;
    logic           zero_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            data_reg         <= '0;
            ptr              <= '0;
            cnt              <= '0;
            FSM_left_right_o <= 1'b0;
            Shift_Value_o    <= '0;
            zero_flag_o      <= 1'b0;
        end else begin
            state            <= state_nxt;
            data_reg         <= data_nxt;
            ptr              <= ptr_nxt;
            cnt              <= cnt_nxt;
            FSM_left_right_o <= lr_nxt;
            Shift_Value_o    <= shift_nxt;
            zero_flag_o      <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_reg;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        lr_nxt    = FSM_left_right_o;
        shift_nxt = Shift_Value_o;
        zero_nxt  = zero_flag_o;

        unique case (state)
            IDLE: begin
                if (load_i) begin
                    data_nxt = Data_i;
                    ptr_nxt  = PTR_START;
                    cnt_nxt  = '0;
                    zero_nxt = 1'b0;
                    // Carry overflow wins over the leading-one search.
                    if (Data_i[SWR-1]) begin
                        lr_nxt    = 1'b0;
                        shift_nxt = CNT_ONE;
                        state_nxt = DONE;
                    end else if (Data_i == '0) begin
                        zero_nxt  = 1'b1;
                        lr_nxt    = 1'b1;
                        shift_nxt = '0;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
            end

            // Data is nonzero below the carry bit here, so a one is always
            // found at or before ptr = 0 and ptr never underflows.
            SCAN: begin
                if (data_reg[ptr]) begin
                    lr_nxt    = 1'b1;
                    shift_nxt = cnt;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    ptr_nxt = ptr - PTR_ONE;
                end
            end

            DONE: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o  = (state != IDLE);
    assign valid_o = (state == DONE);

endmodule

// File: tb/tb_norm_shift_encoder.sv
// Testbench for norm_shift_encoder: directed cases plus randomized sums,
// scoreboarded against a leading-one reference model.
module tb_norm_shift_encoder;

    localparam int SWR = 26;
    localparam int EWR = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_i;
    logic [SWR-1:0] Data_i;
    logic           busy_o;
    logic           valid_o;
    logic           FSM_left_right_o;
    logic [EWR-1:0] Shift_Value_o;
    logic           zero_flag_o;

    norm_shift_encoder #(.SWR(SWR), .EWR(EWR)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_i           (load_i),
        .Data_i           (Data_i),
        .busy_o           (busy_o),
        .valid_o          (valid_o),
        .FSM_left_right_o (FSM_left_right_o),
        .Shift_Value_o    (Shift_Value_o),
        .zero_flag_o      (zero_flag_o)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n++;

    typedef struct {
        logic           lr;
        logic [EWR-1:0] sv;
        logic           zf;
        int unsigned    lat;
        int unsigned    issued;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned checks      = 0;
    int unsigned busy_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: carry -> right by 1; zero -> flag; else left by the number
    // of zeros between the hidden-bit position and the highest set bit.
    function automatic exp_t model(input logic [SWR-1:0] d, input int unsigned issued);
        exp_t e;
        int   top;
        e.issued = issued;
        if (d[SWR-1]) begin
            e.lr = 1'b0; e.sv = 1; e.zf = 1'b0; e.lat = 1;
        end else if (d == 0) begin
            e.lr = 1'b1; e.sv = 0; e.zf = 1'b1; e.lat = 1;
        end else begin
            top = 0;
            for (int i = 0; i < SWR - 1; i++) if (d[i]) top = i;
            e.lr  = 1'b1;
            e.sv  = EWR'((SWR - 2) - top);
            e.zf  = 1'b0;
            e.lat = int'((SWR - 2) - top) + 2;
        end
        return e;
    endfunction

    function automatic logic [SWR-1:0] rand_word();
        int unsigned    k = $urandom_range(0, 9);
        int unsigned    h = $urandom_range(0, SWR - 2);
        logic [SWR-1:0] r = SWR'($urandom);
        logic [SWR-1:0] one = 1;
        if (k == 0) return '0;
        if (k == 1) begin
            r[SWR-1] = 1'b1;
            return r;
        end
        r    = r & ((one << h) - one);
        r[h] = 1'b1;
        return r;
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic [SWR-1:0] d);
        int unsigned guard = 0;
        while (busy_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", {31'd0, busy_o}, 32'd0);
        load_i = 1'b1;
        Data_i = d;
        sb.push_back(model(d, edge_n));
        vectors++;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  {31'd0, busy_o},           32'd0);
        check({tag, "_valid"}, {31'd0, valid_o},          32'd0);
        check({tag, "_lr"},    {31'd0, FSM_left_right_o}, 32'd0);
        check({tag, "_shift"}, {27'd0, Shift_Value_o},    32'd0);
        check({tag, "_zero"},  {31'd0, zero_flag_o},      32'd0);
    endtask

    // Monitor: pops one expectation per valid_o pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy_o) busy_cnt++;
            if (valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    miscompares++;
                    $display("FAIL unexpected_valid: got valid_o=1, expected no pulse (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("lr",       {31'd0, FSM_left_right_o}, {31'd0, mon_e.lr});
                    check("shift",    {27'd0, Shift_Value_o},    {27'd0, mon_e.sv});
                    check("zero",     {31'd0, zero_flag_o},      {31'd0, mon_e.zf});
                    check("latency",  edge_n - mon_e.issued,     mon_e.lat);
                    check("busy_len", busy_cnt,                  mon_e.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int unsigned guard;
        rst    = 1'b1;
        load_i = 1'b0;
        Data_i = '0;
        #3;
        check_reset("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(26'h2000000);
        issue(26'h1000000);
        issue(26'h0000001);
        issue(26'h0040000);
        issue(26'h0000000);
        issue(26'h0800000);

        // A load during SCAN must be ignored.
        issue(26'h0000100);
        repeat (3) @(negedge clk);
        load_i = 1'b1;
        Data_i = 26'h2000000;
        @(negedge clk);
        load_i = 1'b0;

        // Reset in the middle of a long scan aborts it.
        issue(26'h0000001);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("mid_scan_rst");
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(26'h3FFFFFF);

        for (int n = 0; n < 200; n++) issue(rand_word());

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
